// File: rtl/ram_dp_pipe.sv
// Dual-port byte-writable synchronous RAM with valid/ready request and
// response channels. Port A is read/write, port B is read-only.
// Response path per port: optional pipeline stage, then a small in-order
// response buffer that holds data stable under backpressure.

module ram_dp_pipe_rsp #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_err,
  input  logic                  rready,
  output logic                  ready,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err
);

  localparam logic [1:0] LAT = 2'(READ_LATENCY);

  logic                  fin_vld;
  logic [DATA_WIDTH-1:0] fin_data;
  logic                  fin_err;

  logic [DATA_WIDTH-1:0] fd [2];
  logic                  fe [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fcnt;
  logic [1:0]            outstanding;
  logic                  pop;

  // Latency 2 adds one pipeline stage in front of the response buffer.
  if (READ_LATENCY >= 2) begin : g_stage
    logic                  stg_vld;
    logic [DATA_WIDTH-1:0] stg_data;
    logic                  stg_err;

    // Pipeline stage: the valid bit is reset, the payload is not.
    always_ff @(posedge clk) begin
      if (rst) stg_vld <= 1'b0;
      else     stg_vld <= push;
      stg_data <= push_data;
      stg_err  <= push_err;
    end

    assign fin_vld  = stg_vld;
    assign fin_data = stg_data;
    assign fin_err  = stg_err;
  end else begin : g_direct
    assign fin_vld  = push;
    assign fin_data = push_data;
    assign fin_err  = push_err;
  end

  // The valid/ready outputs are masked during reset so nothing stale leaks.
  assign rvalid = (fcnt != 2'd0) && !rst;
  assign pop    = rvalid && rready;
  assign rdata  = rvalid ? fd[rd_ptr] : '0;
  assign err    = rvalid && fe[rd_ptr];
  // Outstanding never exceeds the latency, so the buffer can never overflow.
  assign ready  = !rst && ((outstanding - {1'b0, pop}) < LAT);

  // Response buffer and outstanding-request bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fcnt        <= 2'd0;
      outstanding <= 2'd0;
    end else begin
      if (fin_vld) begin
        fd[wr_ptr] <= fin_data;
        fe[wr_ptr] <= fin_err;
        wr_ptr     <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fcnt        <= fcnt + {1'b0, fin_vld} - {1'b0, pop};
      outstanding <= outstanding + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

module ram_dp_pipe #(
  parameter int BYTE_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SRAM_DEPTH   = 1024,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                               i_CLK,
  input  logic                               i_RST,
  input  logic                               i_A_REQ,
  output logic                               o_A_READY,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   i_A_WE,
  input  logic [ADDR_WIDTH-1:0]              i_A_ADDR,
  input  logic [DATA_WIDTH-1:0]              i_A_WDATA,
  output logic                               o_A_RVALID,
  input  logic                               i_A_RREADY,
  output logic [DATA_WIDTH-1:0]              o_A_RDATA,
  output logic                               o_A_ERR,
  input  logic                               i_B_REQ,
  output logic                               o_B_READY,
  input  logic [ADDR_WIDTH-1:0]              i_B_ADDR,
  output logic                               o_B_RVALID,
  input  logic                               i_B_RREADY,
  output logic [DATA_WIDTH-1:0]              o_B_RDATA,
  output logic                               o_B_ERR
);

  localparam int N_COLS   = DATA_WIDTH / BYTE_WIDTH;
  localparam int ADDR_LSB = (N_COLS > 1) ? $clog2(N_COLS) : 0;
  localparam int IDX_W    = (SRAM_DEPTH > 1) ? $clog2(SRAM_DEPTH) : 1;

  // Contents come up in the array's configuration state and survive reset.
  logic [DATA_WIDTH-1:0] mem [SRAM_DEPTH];

  logic [ADDR_WIDTH-1:0] a_word, b_word;
  logic                  a_in_range, b_in_range;
  logic [IDX_W-1:0]      a_idx, b_idx;
  logic [DATA_WIDTH-1:0] a_old, b_old, a_merged;
  logic [DATA_WIDTH-1:0] a_rsp_data, b_rsp_data;
  logic                  a_acc, b_acc, a_wr;

  assign a_word     = i_A_ADDR >> ADDR_LSB;
  assign b_word     = i_B_ADDR >> ADDR_LSB;
  assign a_in_range = a_word < ADDR_WIDTH'(SRAM_DEPTH);
  assign b_in_range = b_word < ADDR_WIDTH'(SRAM_DEPTH);
  assign a_idx      = a_word[IDX_W-1:0];
  assign b_idx      = b_word[IDX_W-1:0];

  // Both ports see the pre-edge word, so a colliding B read returns old data.
  assign a_old = a_in_range ? mem[a_idx] : '0;
  assign b_old = b_in_range ? mem[b_idx] : '0;

  // Lane merge of write data over the current word.
  always_comb begin
    a_merged = a_old;
    for (int k = 0; k < N_COLS; k++) begin
      if (i_A_WE[k]) a_merged[k*BYTE_WIDTH +: BYTE_WIDTH] = i_A_WDATA[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  assign a_rsp_data = !a_in_range      ? '0       :
                      (RDW_MODE != 0)  ? a_merged : a_old;
  assign b_rsp_data = b_old;

  assign a_acc = i_A_REQ && o_A_READY;
  assign b_acc = i_B_REQ && o_B_READY;
  assign a_wr  = a_acc && a_in_range && (|i_A_WE);

  // Port A lane writes commit on the accepting edge; out-of-range writes drop.
  always_ff @(posedge i_CLK) begin
    if (a_wr) begin
      for (int k = 0; k < N_COLS; k++) begin
        if (i_A_WE[k]) mem[a_idx][k*BYTE_WIDTH +: BYTE_WIDTH] <= i_A_WDATA[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  ram_dp_pipe_rsp #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rsp_a (
    .clk      (i_CLK),
    .rst      (i_RST),
    .push     (a_acc),
    .push_data(a_rsp_data),
    .push_err (!a_in_range),
    .rready   (i_A_RREADY),
    .ready    (o_A_READY),
    .rvalid   (o_A_RVALID),
    .rdata    (o_A_RDATA),
    .err      (o_A_ERR)
  );

  ram_dp_pipe_rsp #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rsp_b (
    .clk      (i_CLK),
    .rst      (i_RST),
    .push     (b_acc),
    .push_data(b_rsp_data),
    .push_err (!b_in_range),
    .rready   (i_B_RREADY),
    .ready    (o_B_READY),
    .rvalid   (o_B_RVALID),
    .rdata    (o_B_RDATA),
    .err      (o_B_ERR)
  );

endmodule

// File: tb/tb_ram_dp_pipe.sv
// Bench for ram_dp_pipe: two instances (latency 1 read-first, latency 2
// write-first) checked every cycle against a transaction-level model.

module tb_ram_dp_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic        a_req    [2];
  logic        a_ready  [2];
  logic [3:0]  a_we     [2];
  logic [31:0] a_addr   [2];
  logic [31:0] a_wdata  [2];
  logic        a_rvalid [2];
  logic        a_rready [2];
  logic [31:0] a_rdata  [2];
  logic        a_err    [2];
  logic        b_req    [2];
  logic        b_ready  [2];
  logic [31:0] b_addr   [2];
  logic        b_rvalid [2];
  logic        b_rready [2];
  logic [31:0] b_rdata  [2];
  logic        b_err    [2];

  ram_dp_pipe #(.READ_LATENCY(1), .RDW_MODE(0)) dut0 (
    .i_CLK(clk), .i_RST(rst[0]),
    .i_A_REQ(a_req[0]), .o_A_READY(a_ready[0]), .i_A_WE(a_we[0]), .i_A_ADDR(a_addr[0]),
    .i_A_WDATA(a_wdata[0]), .o_A_RVALID(a_rvalid[0]), .i_A_RREADY(a_rready[0]),
    .o_A_RDATA(a_rdata[0]), .o_A_ERR(a_err[0]),
    .i_B_REQ(b_req[0]), .o_B_READY(b_ready[0]), .i_B_ADDR(b_addr[0]),
    .o_B_RVALID(b_rvalid[0]), .i_B_RREADY(b_rready[0]), .o_B_RDATA(b_rdata[0]), .o_B_ERR(b_err[0])
  );

  ram_dp_pipe #(.READ_LATENCY(2), .RDW_MODE(1)) dut1 (
    .i_CLK(clk), .i_RST(rst[1]),
    .i_A_REQ(a_req[1]), .o_A_READY(a_ready[1]), .i_A_WE(a_we[1]), .i_A_ADDR(a_addr[1]),
    .i_A_WDATA(a_wdata[1]), .o_A_RVALID(a_rvalid[1]), .i_A_RREADY(a_rready[1]),
    .o_A_RDATA(a_rdata[1]), .o_A_ERR(a_err[1]),
    .i_B_REQ(b_req[1]), .o_B_READY(b_ready[1]), .i_B_ADDR(b_addr[1]),
    .o_B_RVALID(b_rvalid[1]), .i_B_RREADY(b_rready[1]), .o_B_RDATA(b_rdata[1]), .o_B_ERR(b_err[1])
  );

  // Reference model: word memory plus per-port queue of pending responses
  // tagged with the cycle in which each becomes visible.
  logic [31:0] mm     [2][1024];
  logic [31:0] q_data [2][2][4];
  logic        q_err  [2][2][4];
  int          q_due  [2][2][4];
  int          q_n    [2][2];
  int          now;
  int          n_checks;
  int          n_fail;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int rdw_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  // One clock: check all outputs of both DUTs before the edge, advance the model.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      bit          acc  [2];
      bit          popm [2];
      logic [31:0] resp [2];
      bit          rerr [2];
      logic [31:0] aw, bw, old_a, mask;
      for (int p = 0; p < 2; p++) begin
        logic        req, rr, o_rdy, o_vld, o_err;
        logic [31:0] o_data;
        bit          e_vld, e_rdy;
        if (p == 0) begin
          req = a_req[d]; rr = a_rready[d]; o_rdy = a_ready[d];
          o_vld = a_rvalid[d]; o_data = a_rdata[d]; o_err = a_err[d];
        end else begin
          req = b_req[d]; rr = b_rready[d]; o_rdy = b_ready[d];
          o_vld = b_rvalid[d]; o_data = b_rdata[d]; o_err = b_err[d];
        end
        e_vld   = !rst[d] && (q_n[d][p] > 0) && (q_due[d][p][0] <= now);
        popm[p] = e_vld && (rr === 1'b1);
        e_rdy   = !rst[d] && ((q_n[d][p] - (popm[p] ? 1 : 0)) < lat_of(d));
        n_checks++;
        if (o_rdy !== e_rdy) begin
          n_fail++;
          $display("FAIL cycle%0d d%0d p%0d ready: got %b expected %b", now, d, p, o_rdy, e_rdy);
        end
        n_checks++;
        if (o_vld !== e_vld) begin
          n_fail++;
          $display("FAIL cycle%0d d%0d p%0d rvalid: got %b expected %b", now, d, p, o_vld, e_vld);
        end
        if (e_vld) begin
          n_checks++;
          if (o_data !== q_data[d][p][0]) begin
            n_fail++;
            $display("FAIL cycle%0d d%0d p%0d rdata: got %h expected %h", now, d, p, o_data, q_data[d][p][0]);
          end
          n_checks++;
          if (o_err !== q_err[d][p][0]) begin
            n_fail++;
            $display("FAIL cycle%0d d%0d p%0d err: got %b expected %b", now, d, p, o_err, q_err[d][p][0]);
          end
        end
        acc[p] = (req === 1'b1) && e_rdy;
      end
      if (rst[d]) begin
        q_n[d][0] = 0;
        q_n[d][1] = 0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (popm[p]) begin
            for (int i = 0; i < 3; i++) begin
              q_data[d][p][i] = q_data[d][p][i+1];
              q_err[d][p][i]  = q_err[d][p][i+1];
              q_due[d][p][i]  = q_due[d][p][i+1];
            end
            q_n[d][p]--;
          end
        end
        aw      = a_addr[d] / 4;
        bw      = b_addr[d] / 4;
        rerr[0] = (aw >= 1024);
        rerr[1] = (bw >= 1024);
        old_a   = rerr[0] ? 32'h0 : mm[d][aw[9:0]];
        mask    = {{8{a_we[d][3]}}, {8{a_we[d][2]}}, {8{a_we[d][1]}}, {8{a_we[d][0]}}};
        resp[0] = rerr[0] ? 32'h0 :
                  (rdw_of(d) == 1) ? ((old_a & ~mask) | (a_wdata[d] & mask)) : old_a;
        resp[1] = rerr[1] ? 32'h0 : mm[d][bw[9:0]];
        for (int p = 0; p < 2; p++) begin
          if (acc[p]) begin
            q_data[d][p][q_n[d][p]] = resp[p];
            q_err[d][p][q_n[d][p]]  = rerr[p];
            q_due[d][p][q_n[d][p]]  = now + lat_of(d);
            q_n[d][p]++;
          end
        end
        if (acc[0] && !rerr[0]) mm[d][aw[9:0]] = (old_a & ~mask) | (a_wdata[d] & mask);
      end
    end
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; a_req[d] = 1'b0; a_we[d] = 4'h0; a_addr[d] = 32'h0; a_wdata[d] = 32'h0;
      a_rready[d] = 1'b1; b_req[d] = 1'b0; b_addr[d] = 32'h0; b_rready[d] = 1'b1;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic req_a(input int d, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    a_req[d] = 1'b1; a_we[d] = we; a_addr[d] = addr; a_wdata[d] = wdata;
    tick();
    a_req[d] = 1'b0; a_we[d] = 4'h0;
  endtask

  task automatic req_b(input int d, input logic [31:0] addr);
    b_req[d] = 1'b1; b_addr[d] = addr;
    tick();
    b_req[d] = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    rst[0] = 1'b1; rst[1] = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (a_ready[d] !== 1'b0 || b_ready[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset d%0d ready: got %b/%b expected 0/0", d, a_ready[d], b_ready[d]);
      end
      n_checks++;
      if (a_rvalid[d] !== 1'b0 || a_rdata[d] !== 32'h0 || a_err[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset d%0d portA outputs: got %b %h %b expected 0 0 0", d, a_rvalid[d], a_rdata[d], a_err[d]);
      end
      n_checks++;
      if (b_rvalid[d] !== 1'b0 || b_rdata[d] !== 32'h0 || b_err[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset d%0d portB outputs: got %b %h %b expected 0 0 0", d, b_rvalid[d], b_rdata[d], b_err[d]);
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (a_ready[d] !== 1'b1) begin
        n_fail++; $display("FAIL reset_release d%0d ready: got %b expected 1", d, a_ready[d]);
      end
    end
    // Preload every word the later tests touch, one write per cycle.
    for (int w = 0; w <= 64; w++) begin
      int word;
      word = (w == 64) ? 1023 : w;
      for (int d = 0; d < 2; d++) begin
        a_req[d] = 1'b1; a_we[d] = 4'hF; a_addr[d] = word * 4; a_wdata[d] = 32'h1000_0000 + word;
      end
      tick();
    end
    idle_all();
    settle(4);
  endtask

  task automatic test_basic(input int d);
    req_a(d, 4'hF, 32'h10, 32'hDEADBEEF);
    settle(3);
    req_a(d, 4'h0, 32'h10, 32'h0);
    repeat (lat_of(d) - 1) tick();
    n_checks++;
    if (a_rvalid[d] !== 1'b1 || a_rdata[d] !== 32'hDEADBEEF || a_err[d] !== 1'b0) begin
      n_fail++; $display("FAIL basic d%0d read: got %b %h %b expected 1 deadbeef 0", d, a_rvalid[d], a_rdata[d], a_err[d]);
    end
    settle(3);
  endtask

  task automatic test_byte_lanes(input int d);
    logic [31:0] exp_wr;
    exp_wr = (rdw_of(d) == 1) ? 32'h1122AA44 : 32'h11223344;
    req_a(d, 4'hF, 32'h20, 32'h11223344);
    settle(3);
    req_a(d, 4'b0010, 32'h20, 32'h0000AA00);
    repeat (lat_of(d) - 1) tick();
    n_checks++;
    if (a_rvalid[d] !== 1'b1 || a_rdata[d] !== exp_wr) begin
      n_fail++; $display("FAIL lane_write d%0d resp: got %b %h expected 1 %h", d, a_rvalid[d], a_rdata[d], exp_wr);
    end
    settle(3);
    req_a(d, 4'h0, 32'h22, 32'h0);
    repeat (lat_of(d) - 1) tick();
    n_checks++;
    if (a_rvalid[d] !== 1'b1 || a_rdata[d] !== 32'h1122AA44) begin
      n_fail++; $display("FAIL lane_read d%0d: got %b %h expected 1 1122aa44", d, a_rvalid[d], a_rdata[d]);
    end
    settle(3);
  endtask

  task automatic test_out_of_range(input int d);
    req_a(d, 4'hF, 32'h1000, 32'hFFFFFFFF);
    repeat (lat_of(d) - 1) tick();
    n_checks++;
    if (a_rvalid[d] !== 1'b1 || a_err[d] !== 1'b1 || a_rdata[d] !== 32'h0) begin
      n_fail++; $display("FAIL oor_write d%0d: got %b err %b %h expected 1 err 1 0", d, a_rvalid[d], a_err[d], a_rdata[d]);
    end
    settle(3);
    req_a(d, 4'h0, 32'h0, 32'h0);
    repeat (lat_of(d) - 1) tick();
    n_checks++;
    if (a_rdata[d] !== 32'h1000_0000 || a_err[d] !== 1'b0) begin
      n_fail++; $display("FAIL oor_alias d%0d word0: got %h err %b expected 10000000 err 0", d, a_rdata[d], a_err[d]);
    end
    settle(3);
    req_b(d, 32'hFFFF_FFFC);
    repeat (lat_of(d) - 1) tick();
    n_checks++;
    if (b_rvalid[d] !== 1'b1 || b_err[d] !== 1'b1 || b_rdata[d] !== 32'h0) begin
      n_fail++; $display("FAIL oor_b d%0d: got %b err %b %h expected 1 err 1 0", d, b_rvalid[d], b_err[d], b_rdata[d]);
    end
    settle(3);
  endtask

  task automatic test_collision(input int d);
    req_a(d, 4'hF, 32'h40, 32'h0);
    settle(3);
    a_req[d] = 1'b1; a_we[d] = 4'hF; a_addr[d] = 32'h40; a_wdata[d] = 32'h55AA55AA;
    b_req[d] = 1'b1; b_addr[d] = 32'h40;
    tick();
    a_req[d] = 1'b0; a_we[d] = 4'h0; b_req[d] = 1'b0;
    repeat (lat_of(d) - 1) tick();
    n_checks++;
    if (b_rvalid[d] !== 1'b1 || b_rdata[d] !== 32'h0) begin
      n_fail++; $display("FAIL collision d%0d b_old: got %b %h expected 1 0", d, b_rvalid[d], b_rdata[d]);
    end
    settle(3);
    req_b(d, 32'h40);
    repeat (lat_of(d) - 1) tick();
    n_checks++;
    if (b_rdata[d] !== 32'h55AA55AA) begin
      n_fail++; $display("FAIL collision d%0d b_new: got %h expected 55aa55aa", d, b_rdata[d]);
    end
    settle(3);
  endtask

  task automatic test_backpressure();
    a_rready[1] = 1'b0;
    a_req[1] = 1'b1; a_addr[1] = 32'h0;
    tick();
    a_addr[1] = 32'h4;
    tick();
    a_addr[1] = 32'h8;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (a_ready[1] !== 1'b0) begin
        n_fail++; $display("FAIL backpressure ready_low[%0d]: got %b expected 0", i, a_ready[1]);
      end
      n_checks++;
      if (a_rvalid[1] !== 1'b1 || a_rdata[1] !== 32'h1000_0000) begin
        n_fail++; $display("FAIL backpressure hold[%0d]: got %b %h expected 1 10000000", i, a_rvalid[1], a_rdata[1]);
      end
      tick();
    end
    a_rready[1] = 1'b1;
    tick();
    a_addr[1] = 32'hC;
    tick();
    a_req[1] = 1'b0;
    settle(4);
    n_checks++;
    if (a_ready[1] !== 1'b1 || a_rvalid[1] !== 1'b0) begin
      n_fail++; $display("FAIL backpressure recover: got ready %b rvalid %b expected 1 0", a_ready[1], a_rvalid[1]);
    end
  endtask

  task automatic test_back_to_back(input int d);
    for (int i = 0; i < 8; i++) begin
      a_req[d] = 1'b1; a_addr[d] = (i % 4) * 4;
      b_req[d] = 1'b1; b_addr[d] = ((i + 1) % 4) * 4;
      #1;
      n_checks++;
      if (a_ready[d] !== 1'b1 || b_ready[d] !== 1'b1) begin
        n_fail++; $display("FAIL back_to_back d%0d beat%0d ready: got %b/%b expected 1/1", d, i, a_ready[d], b_ready[d]);
      end
      tick();
    end
    a_req[d] = 1'b0; b_req[d] = 1'b0;
    settle(3);
  endtask

  task automatic test_reset_mid(input int d);
    a_rready[d] = 1'b0;
    for (int i = 0; i < lat_of(d); i++) begin
      a_req[d] = 1'b1; a_addr[d] = 32'h4 * i;
      tick();
    end
    a_req[d] = 1'b0;
    rst[d] = 1'b1;
    #1;
    n_checks++;
    if (a_ready[d] !== 1'b0 || a_rvalid[d] !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid d%0d during: got ready %b rvalid %b expected 0 0", d, a_ready[d], a_rvalid[d]);
    end
    tick();
    rst[d] = 1'b0;
    #1;
    n_checks++;
    if (a_ready[d] !== 1'b1 || a_rvalid[d] !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid d%0d after: got ready %b rvalid %b expected 1 0", d, a_ready[d], a_rvalid[d]);
    end
    a_rready[d] = 1'b1;
    settle(3);
    req_a(d, 4'h0, 32'h10, 32'h0);
    repeat (lat_of(d) - 1) tick();
    n_checks++;
    if (a_rdata[d] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL reset_mid d%0d retained: got %h expected deadbeef", d, a_rdata[d]);
    end
    settle(3);
  endtask

  function automatic logic [31:0] rand_addr();
    int r, word;
    r = $urandom_range(0, 15);
    if (r < 12)       word = $urandom_range(0, 15);
    else if (r == 12) word = 1023;
    else if (r == 13) word = 1024;
    else if (r == 14) word = 63;
    else              return $urandom;
    return (word * 4) + $urandom_range(0, 3);
  endfunction

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        rst[d]      = ($urandom_range(0, 149) == 0);
        a_req[d]    = ($urandom_range(0, 3) != 0);
        a_we[d]     = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        a_addr[d]   = rand_addr();
        a_wdata[d]  = $urandom;
        a_rready[d] = ($urandom_range(0, 3) != 0);
        b_req[d]    = ($urandom_range(0, 3) != 0);
        b_addr[d]   = rand_addr();
        b_rready[d] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    idle_all();
    settle(6);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (a_rvalid[d] !== 1'b0 || b_rvalid[d] !== 1'b0) begin
        n_fail++; $display("FAIL random_drain d%0d rvalid: got %b/%b expected 0/0", d, a_rvalid[d], b_rvalid[d]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    now      = 0;
    for (int d = 0; d < 2; d++) begin
      q_n[d][0] = 0;
      q_n[d][1] = 0;
      for (int w = 0; w < 1024; w++) mm[d][w] = 32'h0;
    end
    idle_all();
    test_reset();
    for (int d = 0; d < 2; d++) begin
      test_basic(d);
      test_byte_lanes(d);
      test_out_of_range(d);
      test_collision(d);
    end
    test_backpressure();
    for (int d = 0; d < 2; d++) begin
      test_back_to_back(d);
      test_reset_mid(d);
    end
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dp_pipe.md
Name: ram_dp_pipe

Overview:
Parametrised dual-port byte-writable synchronous RAM. It is the successor to the single-port core SRAM. Port A is read/write and serves the core load/store path. Port B is read-only and serves instruction fetch. Each port has a valid/ready request channel and a valid/ready response channel, with configurable read latency, in-order response buffering under backpressure, read-during-write mode selection and out-of-range error reporting.

Parameters:
BYTE_WIDTH, 8, bits per byte lane
DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH
ADDR_WIDTH, 32, byte-address width on both ports
SRAM_DEPTH, 1024, number of words
READ_LATENCY, 1, request-accept to earliest response, in cycles; legal values 1 or 2
RDW_MODE, 0, port A write response data: 0 = old word (read-first), 1 = new merged word (write-first)
N_COLS (localparam), DATA_WIDTH/BYTE_WIDTH, number of byte lanes
ADDR_LSB (localparam), log2(N_COLS), number of byte-offset bits dropped from the address

Ports:
i_CLK  in  1  clock
i_RST  in  1  synchronous reset, active-high
i_A_REQ  in  1  port A request valid
o_A_READY  out  1  port A request accepted when i_A_REQ && o_A_READY
i_A_WE  in  N_COLS  per-lane write enable; all zero = read
i_A_ADDR  in  ADDR_WIDTH  byte address
i_A_WDATA  in  DATA_WIDTH  write data
o_A_RVALID  out  1  response valid
i_A_RREADY  in  1  response consumed when o_A_RVALID && i_A_RREADY
o_A_RDATA  out  DATA_WIDTH  response data
o_A_ERR  out  1  response error flag
i_B_REQ, o_B_READY, i_B_ADDR, o_B_RVALID, i_B_RREADY, o_B_RDATA, o_B_ERR: same as the port A equivalents; port B has no write signals

Behaviour:
- Clock and reset: single clock i_CLK. Reset i_RST is synchronous, active-high, and takes priority over all other activity.
- Reset values: o_*_READY=0 while i_RST=1; o_*_RVALID=0, o_*_RDATA=0, o_*_ERR=0; outstanding counters and response buffers empty.
- Memory contents are not cleared by reset. They are zero at configuration time only.
- Word index = ADDR >> ADDR_LSB. Low ADDR_LSB bits are ignored; no misalignment error.
- Out-of-range request: word index >= SRAM_DEPTH.
  - The request is still accepted.
  - A write is suppressed entirely.
  - Its response carries RDATA=0 and ERR=1.
- Writes:
  - Only lanes with i_A_WE[k]=1 are updated.
  - Memory is updated at the edge on which the request is accepted.
- Every accepted request, read or write, produces exactly one response. Responses are returned in acceptance order, per port, and are never dropped or duplicated.
- Response data for a port A write: old word if RDW_MODE=0, merged new word if RDW_MODE=1.
- Latency: with no older response pending, o_RVALID rises exactly READ_LATENCY cycles after the accepting edge.
- Response hold under backpressure: while o_RVALID=1 and RREADY=0, RDATA and ERR stay stable.
- Per-port outstanding count = accepted minus consumed.
  - o_READY = !i_RST && (outstanding - pop) < READ_LATENCY, where pop = o_RVALID && i_RREADY in the same cycle.
  - o_READY has a combinational path from i_RREADY.
  - With RREADY held high, each port sustains 1 request per cycle.
- Response storage: each port buffers up to READ_LATENCY responses, as pipeline stages plus a skid buffer.
- Cross-port collision (A write and B read to the same word in the same cycle): B returns the old word regardless of RDW_MODE. The A write completes normally.
- Same-word accesses on consecutive cycles: the later access observes the earlier write.
- Reset during operation:
  - In-flight and buffered responses are discarded.
  - Writes accepted before the reset cycle remain committed.
  - No request is accepted in a reset cycle.
  - o_READY reasserts the cycle after i_RST deasserts.

Test Plan:
- Reset and basic timing, READ_LATENCY=1: reset, write A addr 0x10, WE=1111, data 0xDEADBEEF; read A 0x10 with RREADY=1 -> RVALID exactly 1 cycle after accept, RDATA=0xDEADBEEF, ERR=0.
- Byte lanes and write modes: word at 0x20 = 0x11223344; write WE=0010, data 0x0000AA00 -> response old 0x11223344 (RDW_MODE=0) or new 0x1122AA44 (RDW_MODE=1); subsequent read returns 0x1122AA44.
- Backpressure, READ_LATENCY=2: issue 4 back-to-back reads of 0x0, 0x4, 0x8, 0xC with RREADY=0.
  - 2 are accepted, then READY=0; RDATA stays stable while held.
  - Raise RREADY -> data returned in order; READY recovers; no loss or duplication.
- Out-of-range, SRAM_DEPTH=1024: write A addr 0x1000 with data 0xFFFFFFFF -> response ERR=1, RDATA=0; read of 0x0 confirms word 0 is unchanged (no aliasing).
- Collision: word 0x40 = 0x0; same cycle A writes 0x55AA55AA to 0x40 and B reads 0x40 -> B RDATA=0x0; next B read returns 0x55AA55AA.
- Reset during operation: 2 reads outstanding with RREADY=0, assert i_RST for 1 cycle -> RVALID=0, READY=0 during reset, READY=1 on the following cycle, no stale responses emitted; previously written data is retained.
